// File: rtl/oversample_filter.sv
// Per-channel boxcar oversampling averager: accumulates 2^os samples per channel
// and emits their floor average two cycles after the window-completing sample.
module oversample_filter #(
  parameter int unsigned          N_CHAN    = 8,
  parameter int unsigned          W_CHAN    = 5,
  parameter int unsigned          W_DATA    = 18,
  parameter int unsigned          W_OS      = 4,
  parameter int unsigned          W_WR_ADDR = 16,
  parameter int unsigned          W_WR_CHAN = 16,
  parameter int unsigned          W_WR_DATA = 48,
  parameter logic [W_WR_ADDR-1:0] OS_ADDR   = 16'h0020
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DATA-1:0]    data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DATA-1:0]    data_out
);

  localparam int unsigned MAX_OS = (2 ** W_OS) - 1;
  localparam int unsigned W_SUM  = W_DATA + MAX_OS;
  localparam int unsigned W_CNT  = MAX_OS;
  localparam int unsigned W_IDX  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  logic [W_OS-1:0]         os_mem [N_CHAN] = '{default: '0};
  logic signed [W_SUM-1:0] sum_q  [N_CHAN];
  logic [W_CNT-1:0]        cnt_q  [N_CHAN];

  // Stage 1: completed window sum; stage 2: shifted average
  logic                    p1_valid;
  logic [W_CHAN-1:0]       p1_chan;
  logic signed [W_SUM-1:0] p1_sum;
  logic [W_OS-1:0]         p1_os;
  logic                    p2_valid;
  logic [W_CHAN-1:0]       p2_chan;
  logic [W_DATA-1:0]       p2_data;

  logic                    wr_hit_c;
  logic [W_IDX-1:0]        wr_idx_c;
  logic                    smp_hit_c;
  logic                    smp_take_c;
  logic [W_IDX-1:0]        smp_idx_c;
  logic [W_OS-1:0]         os_cur_c;
  logic [W_CNT-1:0]        cnt_cur_c;
  logic [W_CNT-1:0]        win_lim_c;
  logic                    win_done_c;
  logic signed [W_SUM-1:0] sum_next_c;
  logic                    p1_kill_c;
  logic                    unused_c;

  always_comb begin
    wr_hit_c   = wr_en && (wr_addr == OS_ADDR) && (wr_chan < W_WR_CHAN'(N_CHAN));
    wr_idx_c   = wr_chan[W_IDX-1:0];
    smp_hit_c  = dv_in && (chan_in < W_CHAN'(N_CHAN));
    smp_idx_c  = chan_in[W_IDX-1:0];
    // A sample colliding with a config write to its own channel is dropped
    smp_take_c = smp_hit_c && !(wr_hit_c && (wr_idx_c == smp_idx_c));
    os_cur_c   = os_mem[smp_idx_c];
    cnt_cur_c  = cnt_q[smp_idx_c];
    win_lim_c  = ~({W_CNT{1'b1}} << os_cur_c);
    win_done_c = (cnt_cur_c == win_lim_c);
    sum_next_c = sum_q[smp_idx_c] + W_SUM'($signed(data_in));
    p1_kill_c  = wr_hit_c && (wr_idx_c == p1_chan[W_IDX-1:0]);
  end

  assign unused_c = ^wr_data[W_WR_DATA-1:W_OS];

  // Config memory survives rst_in
  always_ff @(posedge clk_in) begin
    if (wr_hit_c) begin
      os_mem[wr_idx_c] <= wr_data[W_OS-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      p1_valid <= 1'b0;
      p1_chan  <= '0;
      p1_sum   <= '0;
      p1_os    <= '0;
      p2_valid <= 1'b0;
      p2_chan  <= '0;
      p2_data  <= '0;
      dv_out   <= 1'b0;
      chan_out <= '0;
      data_out <= '0;
    end else begin
      if (smp_take_c) begin
        if (win_done_c) begin
          sum_q[smp_idx_c] <= '0;
          cnt_q[smp_idx_c] <= '0;
        end else begin
          sum_q[smp_idx_c] <= sum_next_c;
          cnt_q[smp_idx_c] <= cnt_cur_c + W_CNT'(1);
        end
      end
      if (wr_hit_c) begin
        sum_q[wr_idx_c] <= '0;
        cnt_q[wr_idx_c] <= '0;
      end

      p1_valid <= smp_take_c && win_done_c;
      p1_chan  <= chan_in;
      p1_sum   <= sum_next_c;
      p1_os    <= os_cur_c;

      // A write to the channel of an in-flight result discards it
      p2_valid <= p1_valid && !p1_kill_c;
      p2_chan  <= p1_chan;
      p2_data  <= W_DATA'(p1_sum >>> p1_os);

      dv_out <= p2_valid;
      if (p2_valid) begin
        chan_out <= p2_chan;
        data_out <= p2_data;
      end
    end
  end

endmodule

// File: doc/oversample_filter.md
Name: oversample_filter

Overview:
- Per-channel boxcar oversampling averager that sits directly downstream of the PID instruction dispatcher.
- Consumes the dispatcher's instruction stream (dv, channel, data) and accumulates 2^os samples per channel.
- Emits one averaged sample per channel per completed window to the PID arithmetic stage.
- Oversample ratio per channel is set over the shared write bus (wr_en/wr_addr/wr_chan/wr_data).

Parameters:
N_CHAN, 8, number of PID channels
W_CHAN, 5, channel index width
W_DATA, 18, signed sample width (two's complement)
W_OS, 4, width of log2 oversample ratio; MAX_OS = 2^W_OS - 1
W_WR_ADDR, 16, write-bus address width
W_WR_CHAN, 16, write-bus channel width
W_WR_DATA, 48, write-bus data width
OS_ADDR, 16'h0020, write-bus address of the per-channel os register

Ports:
clk_in  input  1  system clock; single clock domain
rst_in  input  1  synchronous, active-high reset
dv_in  input  1  input sample valid
chan_in  input  W_CHAN  channel of input sample
data_in  input  W_DATA  signed input sample
wr_en  input  1  config write strobe
wr_addr  input  W_WR_ADDR  config address
wr_chan  input  W_WR_CHAN  config channel
wr_data  input  W_WR_DATA  config data
dv_out  output  1  averaged sample valid (1-cycle pulse)
chan_out  output  W_CHAN  channel of averaged sample
data_out  output  W_DATA  signed averaged sample

Behaviour:
- One clock (clk_in); reset is synchronous and active-high (rst_in).
- Config memory os_mem[N_CHAN] (W_OS bits each):
  - Initialised to 0 at configuration; not cleared by rst_in.
  - Written when wr_en && wr_addr==OS_ADDR && wr_chan<N_CHAN: os_mem[wr_chan] <= wr_data[W_OS-1:0].
  - Writes with wr_chan>=N_CHAN are ignored.
- Per-channel state: signed accumulator sum (W_DATA+MAX_OS bits, no overflow possible) and sample counter cnt (MAX_OS bits).
- Qualifying sample: dv_in && chan_in<N_CHAN. All other dv_in pulses are ignored with no state change.
- Qualifying sample on channel c with n = os_mem[c]:
  - If cnt[c] == 2^n - 1 (window complete): result = (sum[c] + data_in) >>> n (arithmetic shift, floor rounding); emit result; clear sum[c] and cnt[c].
  - Otherwise: sum[c] += sign-extended data_in; cnt[c] += 1.
  - n=0 is pass-through: every sample is emitted unchanged.
- Latency: exactly 2 cycles. A completing sample accepted at edge t gives dv_out=1 in the cycle after edge t+2, with chan_out=c and data_out=result[W_DATA-1:0].
- Result always fits W_DATA bits, since the average of in-range values is in range.
- Throughput: one sample per cycle, including back-to-back samples on the same channel. The pipeline must forward in-flight sums; no stalls, no dropped samples.
- dv_out is a single-cycle pulse per completed window.
- chan_out and data_out hold their last values when dv_out=0.
- Config write to channel c (valid address and channel):
  - Clears sum[c] and cnt[c] in the write cycle.
  - Any sample for c accepted in the same or previous cycle that has not yet emitted is discarded: no dv_out.
  - A sample on c in the same cycle as the write is dropped.
  - Other channels are unaffected.
- New os value applies from the first sample accepted after the write cycle.
- Reset:
  - dv_out=0, chan_out=0, data_out=0.
  - All sum and cnt cleared; pipeline flushed.
  - dv_in is ignored during reset, and in-flight samples produce no output.

Test Plan:
1. os[2]=0; dv_in chan=2 data=100 -> 2 cycles later dv_out=1, chan_out=2, data_out=100, for one cycle only.
2. os[0]=2; back-to-back samples 10,11,12,13 on ch0 -> no output for the first three; a single dv_out with data_out=11 (46>>>2) 2 cycles after the 4th.
3. os[1]=1; samples -3,-4 on ch1 -> data_out=-4 (floor of -3.5); os[1]=4 with 16 samples of 131071 -> 131071; 16 of -131072 -> -131072.
4. os[0]=os[1]=1; alternating ch0:2,ch1:20,ch0:4,ch1:40 every cycle -> outputs ch0=3, then ch1=30, on consecutive cycles.
5. os[3]=2; two samples of 100, then write os[3]=2, then four samples of 8 -> exactly one output, 8; write coincident with a ch3 sample -> that sample dropped.
6. Partial ch0 window plus a completing ch1 sample in flight, then assert rst_in 1 cycle -> no dv_out; next full ch0 window averages only post-reset samples; os values retained.
